// File: rtl/shift_control_if.sv
// shift_control_if: operator switch inputs and A/B register strobes exchanged by shift_control.
interface shift_control_if #(parameter int N = 8);
    localparam int W = $clog2(N + 1);
    logic execute;
    logic load_a;
    logic load_b;
    logic ld_a;
    logic ld_b;
    logic shift_en;
    logic busy;
    logic done;
    logic [W-1:0] count;
    modport master(input execute, load_a, load_b, output ld_a, ld_b, shift_en, busy, done, count);
    modport slave(output execute, load_a, load_b, input ld_a, ld_b, shift_en, busy, done, count);
endinterface

// File: rtl/shift_control.sv
// shift_control: turns Execute/LoadA/LoadB switches into load strobes and N-cycle shift runs.
// Define SHIFT_CTRL_SYNC_EN to pass the three switch inputs through two-flop synchronizers.
module shift_control #(parameter int N = 8) (
    input logic Clk,
    input logic Reset,
    shift_control_if.master bus
);
    localparam int W = $clog2(N + 1);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] FULL = W'(N);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t state;
    logic [W-1:0] cnt;
    logic shift_q, done_q;
    logic execute_s, load_a_s, load_b_s;
`ifdef SHIFT_CTRL_SYNC_EN
    logic [1:0] e_sync, a_sync, b_sync;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            e_sync <= '0;
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            e_sync <= {e_sync[0], bus.execute};
            a_sync <= {a_sync[0], bus.load_a};
            b_sync <= {b_sync[0], bus.load_b};
        end
    end
    assign execute_s = e_sync[1];
    assign load_a_s = a_sync[1];
    assign load_b_s = b_sync[1];
`else
    assign execute_s = bus.execute;
    assign load_a_s = bus.load_a;
    assign load_b_s = bus.load_b;
`endif
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            shift_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (execute_s) begin
                    state <= SHIFT;
                    cnt <= '0;
                    shift_q <= 1'b1;
                end
                SHIFT: if (cnt == LAST) begin
                    state <= HOLD;
                    cnt <= FULL;
                    shift_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt <= cnt + W'(1);
                end
                HOLD: if (!execute_s) begin
                    state <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Load strobes only exist in IDLE, so they can never coincide with a shift.
    assign bus.ld_a = !Reset && state == IDLE && load_a_s;
    assign bus.ld_b = !Reset && state == IDLE && load_b_s;
    assign bus.shift_en = !Reset && shift_q;
    assign bus.busy = !Reset && shift_q;
    assign bus.done = !Reset && done_q;
    assign bus.count = Reset ? '0 : cnt;
endmodule

// File: tb/tb_shift_control.sv
// tb_shift_control: directed checks of reset, loads, shift runs and mid-run reset for shift_control.
module tb_shift_control;
`ifdef SHIFT_CTRL_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passes = 0;
    int total = 0;
    shift_control_if #(.N(8)) bus();
    shift_control #(.N(8)) dut(.Clk(clk), .Reset(rst), .bus(bus.master));
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask
    task automatic run(input int len, input int hold, output int nsh, output int first, output int last);
        nsh = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < len; i++) begin
            cyc();
            bus.execute = (i < hold);
            #3;
            if (bus.shift_en) begin
                nsh++;
                if (first < 0) first = i;
                last = i;
            end
        end
    endtask
    logic sh[30], lb[30], dn[30], by[30];
    int cn[30];
    int nsh, first, last, ovl, na, nb, ns;
    initial begin
        bus.execute = 1'b0;
        bus.load_a = 1'b0;
        bus.load_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            rst = 1'b1;
            {bus.execute, bus.load_a, bus.load_b} = 3'($urandom);
            #3;
            chk("reset_outputs", int'({bus.ld_a, bus.ld_b, bus.shift_en, bus.busy, bus.done, bus.count}), 0);
        end
        cyc();
        rst = 1'b0;
        {bus.execute, bus.load_a, bus.load_b} = 3'b000;
        #3;
        chk("post_reset_count", int'(bus.count), 0);
        chk("post_reset_busy", int'(bus.busy), 0);
        chk("post_reset_done", int'(bus.done), 0);
        na = 0;
        nb = 0;
        ns = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            bus.load_a = (i < 3);
            #3;
            na += int'(bus.ld_a);
            nb += int'(bus.ld_b);
            ns += int'(bus.shift_en);
        end
        chk("load_a_cycles", na, 3);
        chk("load_a_ld_b", nb, 0);
        chk("load_a_shift", ns, 0);
        for (int i = 0; i < 30; i++) begin
            cyc();
            bus.execute = (i < 20);
            bus.load_b = 1'b1;
            #3;
            sh[i] = bus.shift_en;
            lb[i] = bus.ld_b;
            dn[i] = bus.done;
            by[i] = bus.busy;
            cn[i] = int'(bus.count);
        end
        nsh = 0;
        first = -1;
        last = -1;
        ovl = 0;
        for (int i = 0; i < 30; i++) begin
            if (sh[i]) begin
                nsh++;
                if (first < 0) first = i;
                last = i;
            end
            if (sh[i] && lb[i]) ovl++;
        end
        chk("run_shift_total", nsh, 8);
        chk("run_first_shift", first, 1 + L);
        chk("run_last_shift", last, 8 + L);
        chk("run_ld_b_overlap", ovl, 0);
        chk("run_ld_b_idle", int'(lb[L]), 1);
        chk("run_busy_first", int'(by[1 + L]), 1);
        chk("run_done_early", int'(dn[8 + L]), 0);
        chk("run_done_set", int'(dn[9 + L]), 1);
        chk("run_count_full", cn[9 + L], 8);
        chk("run_done_held", int'(dn[19]), 1);
        chk("run_count_held", cn[19], 8);
        chk("run_done_cleared", int'(dn[21 + L]), 0);
        chk("run_idle_ld_b", int'(lb[21 + L]), 1);
        chk("run_count_kept", cn[21 + L], 8);
        bus.load_b = 1'b0;
        for (int i = 0; i <= 4 + L; i++) begin
            cyc();
            bus.execute = 1'b1;
            if (i == 4 + L) begin
                rst = 1'b1;
                bus.execute = 1'b0;
            end
            #3;
            if (i == 3 + L) chk("abort_third_shift", int'(bus.shift_en), 1);
            if (i == 3 + L) chk("abort_third_count", int'(bus.count), 2);
            if (i == 4 + L) chk("abort_reset_shift", int'(bus.shift_en), 0);
        end
        cyc();
        rst = 1'b0;
        #3;
        chk("abort_after_shift", int'(bus.shift_en), 0);
        chk("abort_after_count", int'(bus.count), 0);
        chk("abort_after_busy", int'(bus.busy), 0);
        run(6, 0, nsh, first, last);
        chk("abort_no_shifts", nsh, 0);
        run(16, 12, nsh, first, last);
        chk("fresh_shift_total", nsh, 8);
        chk("fresh_first_shift", first, 1 + L);
        chk("fresh_last_shift", last, 8 + L);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
